// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential non-restoring divider: FSM states,
// default operand width and the iteration-counter width helper.
package seq_divider_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Counter only has to reach WIDTH-1.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/nr_div_step.sv
// One non-restoring division iteration: shift the remainder/quotient pair left,
// add or subtract the divisor according to the remainder sign, insert a quotient bit.
module nr_div_step
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] sum;

    // The true result always fits in WIDTH+1 signed bits, so dropping the old
    // sign bit during the shift and working modulo 2^(WIDTH+1) is exact.
    always_comb begin
        shifted = {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};
        if (rem_i[WIDTH]) begin
            sum = shifted + {1'b0, dvs_i};
        end else begin
            sum = shifted - {1'b0, dvs_i};
        end
        rem_o = sum;
        quo_o = {quo_i[WIDTH-2:0], ~sum[WIDTH]};
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed/unsigned divider, one quotient bit per cycle.
// Optional macro SEQ_DIVIDER_OVF_DETECT_EN flags signed MIN / -1 via exception.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             ready,
    output logic             exception,
    output logic [1:0]       dbg_state_o
);

    localparam int CW = cnt_width(WIDTH);

`ifdef SEQ_DIVIDER_OVF_DETECT_EN
    localparam logic OVF_DETECT = 1'b1;
`else
    localparam logic OVF_DETECT = 1'b0;
`endif

    // Handshake: start is accepted only in IDLE or DONE (ignored while busy);
    // ready is a one-cycle pulse in DONE with no backpressure; results hold
    // until the next accepted operation completes.

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             exc_q, exc_d;

    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] rem_mag, quo_res, rem_res;

    assign dvd_neg = is_signed & dividend[WIDTH-1];
    assign dvs_neg = is_signed & divisor[WIDTH-1];
    assign dvd_mag = dvd_neg ? -dividend : dividend;
    assign dvs_mag = dvs_neg ? -divisor : divisor;

    nr_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // Final correction and sign application, used in FIX.
    always_comb begin
        rem_mag = rem_q[WIDTH] ? (rem_q[WIDTH-1:0] + dvs_q) : rem_q[WIDTH-1:0];
        quo_res = neg_quo_q ? -quo_q : quo_q;
        rem_res = neg_rem_q ? -rem_mag : rem_mag;
        if (dz_q) begin
            quo_res = '1;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        dz_d        = dz_q;
        ovf_d       = ovf_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        exc_d       = exc_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    cnt_d     = '0;
                    rem_d     = '0;
                    quo_d     = dvd_mag;
                    dvs_d     = dvs_mag;
                    neg_quo_d = dvd_neg ^ dvs_neg;
                    neg_rem_d = dvd_neg;
                    dz_d      = (divisor == '0);
                    ovf_d     = is_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                                && (divisor == '1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_FIX;
                    cnt_d   = '0;
                end
            end
            ST_FIX: begin
                quotient_d  = quo_res;
                remainder_d = rem_res;
                exc_d       = dz_q | (OVF_DETECT & ovf_q);
                state_d     = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            exc_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            dz_q        <= dz_d;
            ovf_q       <= ovf_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            exc_q       <= exc_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign exception   = exc_q;
    assign busy        = (state_q == ST_RUN) || (state_q == ST_FIX);
    assign ready       = (state_q == ST_DONE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed and random divides on a 32-bit and an 8-bit
// instance, checked against an arithmetic reference model.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst32, start32, s32;
    logic [31:0] a32, b32, q32, r32;
    logic        busy32, rdy32, exc32;
    logic [1:0]  st32;
    logic        rst8, start8, s8;
    logic [7:0]  a8, b8, q8, r8;
    logic        busy8, rdy8, exc8;
    logic [1:0]  st8;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [31:0] prev_q32 = '0;

`ifdef SEQ_DIVIDER_OVF_DETECT_EN
    localparam bit OVF_EXP = 1'b1;
`else
    localparam bit OVF_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(32)) dut32 (
        .clock(clk), .reset(rst32), .start(start32), .is_signed(s32),
        .dividend(a32), .divisor(b32), .quotient(q32), .remainder(r32),
        .busy(busy32), .ready(rdy32), .exception(exc32), .dbg_state_o(st32)
    );

    seq_divider #(.WIDTH(8)) dut8 (
        .clock(clk), .reset(rst8), .start(start8), .is_signed(s8),
        .dividend(a8), .divisor(b8), .quotient(q8), .remainder(r8),
        .busy(busy8), .ready(rdy8), .exception(exc8), .dbg_state_o(st8)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: truncating division from plain integer arithmetic.
    function automatic void ref_div(input int w, input bit s, input logic [63:0] a_in,
                                    input logic [63:0] b_in, output logic [63:0] q,
                                    output logic [63:0] r, output bit exc);
        logic [63:0] mask, a, b;
        longint sa, sb;
        mask = (64'(1) << w) - 64'(1);
        a = a_in & mask;
        b = b_in & mask;
        exc = 1'b0;
        if (b == 0) begin
            q = mask; r = a; exc = 1'b1;
        end else if (s) begin
            sa = longint'(a << (64 - w)); sa = sa >>> (64 - w);
            sb = longint'(b << (64 - w)); sb = sb >>> (64 - w);
            if (sa == -(longint'(1) << (w - 1)) && sb == -1) begin
                q = a; r = 0; exc = OVF_EXP;
            end else begin
                q = 64'(sa / sb) & mask;
                r = 64'(sa % sb) & mask;
            end
        end else begin
            q = a / b; r = a % b;
        end
    endfunction

    // Caller is at a negedge; start is driven now and accepted at the next posedge.
    task automatic op32(input bit s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input bit ee,
                        input bit poke_busy);
        int cyc;
        s32 = s; a32 = a; b32 = b; start32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start32 = 1'b0; a32 = $urandom; b32 = $urandom; s32 = 1'($urandom_range(0, 1));
        cyc = 1;
        while (!rdy32 && cyc < 100) begin
            if (cyc == 5) begin
                check_val("busy32_run", 64'(busy32), 64'd1);
                check_val("q32_hold", 64'(q32), 64'(prev_q32));
                if (poke_busy) start32 = 1'b1;
            end
            if (cyc == 6) start32 = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check_val("lat32", 64'(cyc), 64'd34);
        check_val("quo32", 64'(q32), 64'(eq));
        check_val("rem32", 64'(r32), 64'(er));
        check_val("exc32", 64'(exc32), 64'(ee));
        check_val("busy32_done", 64'(busy32), 64'd0);
        prev_q32 = eq;
    endtask

    task automatic op8(input bit s, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eq, input logic [7:0] er, input bit ee);
        int cyc;
        s8 = s; a8 = a; b8 = b; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        cyc = 1;
        while (!rdy8 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check_val("lat8", 64'(cyc), 64'd10);
        check_val("quo8", 64'(q8), 64'(eq));
        check_val("rem8", 64'(r8), 64'(er));
        check_val("exc8", 64'(exc8), 64'(ee));
    endtask

    initial begin
        logic [63:0] mq, mr;
        bit me, s;
        logic [31:0] a, b;
        int mode, pulses;

        rst32 = 1'b1; rst8 = 1'b1; start32 = 1'b0; start8 = 1'b0;
        s32 = 1'b0; s8 = 1'b0; a32 = '0; b32 = '0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        rst32 = 1'b0; rst8 = 1'b0;
        check_val("rst_state32", 64'(st32), 64'd0);
        check_val("rst_quo32", 64'(q32), 64'd0);
        check_val("rst_rem32", 64'(r32), 64'd0);
        check_val("rst_flags32", 64'({busy32, rdy32, exc32}), 64'd0);
        check_val("rst_flags8", 64'({busy8, rdy8, exc8, q8, r8}), 64'd0);

        // Directed cases with hand-derived results.
        op32(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
        op32(1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0);
        op32(1'b1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 1'b0, 1'b0);
        op32(1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 1'b0);
        op32(1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 1'b0);
        op32(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, OVF_EXP, 1'b0);
        op32(1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 1'b0);
        op32(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 1'b1);

        // Results hold in IDLE.
        repeat (4) @(negedge clk);
        check_val("idle_hold_quo32", 64'(q32), 64'd100);
        check_val("idle_state32", 64'(st32), 64'd0);

        // Reset ten cycles into RUN aborts the operation.
        s32 = 1'b0; a32 = 32'd77; b32 = 32'd3; start32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start32 = 1'b0;
        repeat (10) @(negedge clk);
        check_val("busy32_pre_rst", 64'(busy32), 64'd1);
        rst32 = 1'b1; start32 = 1'b1;
        @(negedge clk);
        rst32 = 1'b0; start32 = 1'b0;
        check_val("abort_state32", 64'(st32), 64'd0);
        check_val("abort_quo32", 64'(q32), 64'd0);
        check_val("abort_rem32", 64'(r32), 64'd0);
        check_val("abort_flags32", 64'({busy32, rdy32, exc32}), 64'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (rdy32) pulses++;
        end
        check_val("abort_no_ready32", 64'(pulses), 64'd0);
        prev_q32 = '0;

        repeat (40) begin
            s = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            mode = $urandom_range(0, 9);
            b = (mode == 0) ? 32'd0 : (mode == 1) ? 32'($urandom_range(1, 15)) :
                (mode == 2) ? 32'hFFFFFFFF : $urandom;
            ref_div(32, s, 64'(a), 64'(b), mq, mr, me);
            op32(s, a, b, mq[31:0], mr[31:0], me, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        // Back-to-back on the 8-bit instance: second start lands in the DONE cycle.
        @(negedge clk);
        op8(1'b0, 8'd17, 8'd5, 8'd3, 8'd2, 1'b0);
        op8(1'b0, 8'd200, 8'd3, 8'd66, 8'd2, 1'b0);
        op8(1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, OVF_EXP);
        repeat (40) begin
            s = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(0, 255));
            ref_div(8, s, 64'(a), 64'(b), mq, mr, me);
            op8(s, a[7:0], b[7:0], mq[7:0], mr[7:0], me);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits (legal range 4..64).
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request; accepted only in IDLE or DONE.
REQ-005 SHALL have port is_signed  input  1  1 = two's-complement divide, 0 = unsigned; sampled with start.
REQ-006 SHALL have port dividend  input  WIDTH  numerator; sampled with start.
REQ-007 SHALL have port divisor  input  WIDTH  denominator; sampled with start.
REQ-008 SHALL have port quotient  output  WIDTH  result quotient.
REQ-009 SHALL have port remainder  output  WIDTH  result remainder.
REQ-010 SHALL have port busy  output  1  high while in RUN or FIX.
REQ-011 SHALL have port ready  output  1  one-cycle completion pulse.
REQ-012 SHALL have port exception  output  1  error flag, valid with ready.

Function
REQ-013 SHALL implement states IDLE, RUN, FIX, DONE: IDLE->RUN on accepted start; RUN for exactly WIDTH cycles; RUN->FIX; FIX->DONE; DONE->RUN on start, else DONE->IDLE.
REQ-014 SHALL register is_signed, dividend and divisor on the accepting edge; later input changes SHALL NOT affect the operation.
REQ-015 SHALL ignore start while busy is high (no restart, no error).
REQ-016 SHALL use non-restoring division on operand magnitudes, one quotient bit per RUN cycle, with a 2*WIDTH remainder/quotient register.
REQ-017 SHALL in FIX add the divisor back to a negative partial remainder, then apply signs: quotient negated iff is_signed and operand signs differ; remainder negated iff is_signed and dividend negative.
REQ-018 SHALL assert ready during exactly the single DONE cycle, WIDTH+2 cycles after the cycle in which start was accepted.
REQ-019 SHALL hold quotient, remainder and exception stable from DONE until the next accepted start completes.
REQ-020 SHALL, for divisor = 0, produce quotient all-ones, remainder = dividend, exception = 1, with unchanged latency.
REQ-021 SHALL, for signed MIN / -1, produce quotient = MIN and remainder = 0.
REQ-022 SHALL deassert exception for any non-error completion.

Reset
REQ-023 SHALL on reset enter IDLE and clear quotient, remainder, busy, ready, exception and all internal registers to 0.
REQ-024 SHALL let reset override start in the same cycle, and abort any in-progress operation with no ready pulse.

Configuration
REQ-025 SHALL honour macro SEQ_DIVIDER_OVF_DETECT_EN: defined -> signed MIN / -1 asserts exception with ready; undefined -> exception is never asserted for that case (results per REQ-021 either way).

Structure
REQ-026 SHALL place the state enum, default WIDTH and the counter-width function in shared package seq_divider_pkg.
REQ-027 SHALL implement one iteration (shift, add/subtract, quotient-bit insert) as sub-module nr_div_step, instantiated once.

Verification
REQ-028 SHALL test WIDTH=32 unsigned 100/7 -> quotient 14, remainder 2, exception 0, ready exactly 34 cycles after start.
REQ-029 SHALL test signed -100/7 -> quotient 0xFFFFFFF2, remainder 0xFFFFFFFE; signed 100/-7 -> quotient 0xFFFFFFF2, remainder 2.
REQ-030 SHALL test 5/0 -> quotient 0xFFFFFFFF, remainder 5, exception 1 with ready.
REQ-031 SHALL test signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, exception 1 only with SEQ_DIVIDER_OVF_DETECT_EN.
REQ-032 SHALL test reset asserted 10 cycles into RUN -> IDLE, all outputs 0, no ready; a start pulsed while busy is ignored.
REQ-033 SHALL test WIDTH=8 back-to-back: start in DONE cycle with 200/3 unsigned -> next ready 10 cycles later, quotient 66, remainder 2.
